// File: rtl/countdown_timer_core_if.sv
// Control/display bundle for the MM:SS countdown core.
// master drives switches and pulses; slave is the timer core.
interface countdown_timer_core_if #(
    parameter int LED_W = 10
);
    logic [7:0]       sw_val;
    logic             set_pulse;
    logic             go_pulse;
    logic             clr_pulse;
    logic             flash_en;
    logic [3:0]       min_tens;
    logic [3:0]       min_ones;
    logic [3:0]       sec_tens;
    logic [3:0]       sec_ones;
    logic [2:0]       state_o;
    logic             running;
    logic             expired;
    logic [LED_W-1:0] ledr;

    modport master (
        output sw_val, set_pulse, go_pulse, clr_pulse, flash_en,
        input  min_tens, min_ones, sec_tens, sec_ones,
        input  state_o, running, expired, ledr
    );

    modport slave (
        input  sw_val, set_pulse, go_pulse, clr_pulse, flash_en,
        output min_tens, min_ones, sec_tens, sec_ones,
        output state_o, running, expired, ledr
    );
endinterface

// File: rtl/countdown_timer_core.sv
// MM:SS countdown core: switch load, run/pause, BCD borrow
// decrement once per prescaled tick, LED flash on expiry.
module countdown_timer_core #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1,
    parameter int FLASH_HZ = 2,
    parameter int LED_W    = 10
) (
    input logic CLOCK_50,
    input logic reset,
    countdown_timer_core_if.slave bus
);
    localparam int PRESCALE  = CLK_HZ / TICK_HZ;
    localparam int FLASH_DIV = CLK_HZ / (2 * FLASH_HZ);
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    typedef enum logic [2:0] {
        S_SET_SEC = 3'd0,
        S_SET_MIN = 3'd1,
        S_RUN     = 3'd2,
        S_PAUSE   = 3'd3,
        S_EXP     = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    mt_q, mt_d, mo_q, mo_d;
    logic [3:0]    st_q, st_d, so_q, so_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          flash_q, flash_d;
    logic          tick_q, tick_d;

    logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
    logic       all_zero, dec_zero, wrap, fwrap;

    function automatic logic [3:0] clamp(input logic [3:0] v,
                                         input logic [3:0] m);
        return (v > m) ? m : v;
    endfunction

    assign all_zero = (mt_q == 4'd0) && (mo_q == 4'd0) &&
                      (st_q == 4'd0) && (so_q == 4'd0);
    assign wrap  = (presc_q == PW'(PRESCALE - 1));
    assign fwrap = (fcnt_q == FW'(FLASH_DIV - 1));

    // BCD decrement with borrow chain; only used when time is non-zero
    always_comb begin
        dec_mt = mt_q;
        dec_mo = mo_q;
        dec_st = st_q;
        dec_so = so_q;
        if (so_q != 4'd0) begin
            dec_so = so_q - 4'd1;
        end else begin
            dec_so = 4'd9;
            if (st_q != 4'd0) begin
                dec_st = st_q - 4'd1;
            end else begin
                dec_st = 4'd5;
                if (mo_q != 4'd0) begin
                    dec_mo = mo_q - 4'd1;
                end else begin
                    dec_mo = 4'd9;
                    dec_mt = mt_q - 4'd1;
                end
            end
        end
    end

    assign dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) &&
                      (dec_st == 4'd0) && (dec_so == 4'd0);

    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mo_d    = mo_q;
        st_d    = st_q;
        so_d    = so_q;
        presc_d = presc_q;
        fcnt_d  = '0;
        flash_d = 1'b0;
        tick_d  = 1'b0;
        if (bus.clr_pulse) begin
            state_d = S_SET_SEC;
            mt_d    = 4'd0;
            mo_d    = 4'd0;
            st_d    = 4'd0;
            so_d    = 4'd0;
            presc_d = '0;
        end else begin
            unique case (state_q)
                S_SET_SEC: begin
                    if (bus.go_pulse) begin
                        state_d = all_zero ? S_EXP : S_RUN;
                        presc_d = '0;
                    end else begin
                        st_d = clamp(bus.sw_val[7:4], 4'd5);
                        so_d = clamp(bus.sw_val[3:0], 4'd9);
                        if (bus.set_pulse) state_d = S_SET_MIN;
                    end
                end
                S_SET_MIN: begin
                    if (bus.go_pulse) begin
                        state_d = all_zero ? S_EXP : S_RUN;
                        presc_d = '0;
                    end else begin
                        mt_d = clamp(bus.sw_val[7:4], 4'd9);
                        mo_d = clamp(bus.sw_val[3:0], 4'd9);
                    end
                end
                S_RUN: begin
                    presc_d = wrap ? '0 : presc_q + PW'(1);
                    tick_d  = wrap;
                    if (bus.go_pulse) state_d = S_PAUSE;
                end
                S_PAUSE: begin
                    if (bus.go_pulse) state_d = S_RUN;
                end
                S_EXP: begin
                    mt_d    = 4'd0;
                    mo_d    = 4'd0;
                    st_d    = 4'd0;
                    so_d    = 4'd0;
                    fcnt_d  = fwrap ? '0 : fcnt_q + FW'(1);
                    flash_d = fwrap ? ~flash_q : flash_q;
                end
                default: begin
                    state_d = S_SET_SEC;
                    mt_d    = 4'd0;
                    mo_d    = 4'd0;
                    st_d    = 4'd0;
                    so_d    = 4'd0;
                    presc_d = '0;
                end
            endcase
            // a tick latched just before a pause still lands
            if (tick_q && !all_zero &&
                (state_q == S_RUN || state_q == S_PAUSE)) begin
                mt_d = dec_mt;
                mo_d = dec_mo;
                st_d = dec_st;
                so_d = dec_so;
                if (dec_zero) state_d = S_EXP;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= S_SET_SEC;
            mt_q    <= 4'd0;
            mo_q    <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
            presc_q <= '0;
            fcnt_q  <= '0;
            flash_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mt_q    <= mt_d;
            mo_q    <= mo_d;
            st_q    <= st_d;
            so_q    <= so_d;
            presc_q <= presc_d;
            fcnt_q  <= fcnt_d;
            flash_q <= flash_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.min_tens = mt_q;
    assign bus.min_ones = mo_q;
    assign bus.sec_tens = st_q;
    assign bus.sec_ones = so_q;
    assign bus.state_o  = state_q;
    assign bus.running  = (state_q == S_RUN);
    assign bus.expired  = (state_q == S_EXP);
    assign bus.ledr     = {LED_W{flash_q & bus.flash_en}};
endmodule
